// File: rtl/serdes_cipher_deserializer.sv
// Receive-side deserializer: re-forms MSB-first cipher bytes, strips the key byte by XOR,
// and queues the results in a first-word fall-through FIFO drained over valid/ready.
module serdes_cipher_deserializer #(
   parameter logic [7:0]  KEY_BYTE   = 8'h34,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_valid,
   input  logic       bit_in,
   input  logic       frame_start,
   input  logic       clr_ovf,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       overflow,
   output logic [7:0] frame_count,
   output logic       busy
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

   logic [6:0]       r_shift;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [OCC_W-1:0] r_occ;
   logic [7:0]       r_out_data;
   logic             r_out_valid;
   logic             r_overflow;
   logic [7:0]       r_frame_count;
   logic             r_busy;

   logic             w_complete;
   logic [7:0]       w_byte;
   logic             w_pop;
   logic             w_full;
   logic             w_push;
   logic             w_drop;
   logic [6:0]       w_shift_nxt;
   logic [2:0]       w_cnt_nxt;
   logic [OCC_W-1:0] w_occ_nxt;
   logic [PTR_W-1:0] w_rd_nxt;
   logic [7:0]       w_head_nxt;

   // Assembly, push/pop decisions and the next FIFO head
   always_comb begin
      w_complete  = bit_valid && !frame_start && (r_bit_cnt == 3'd7);
      w_byte      = {r_shift, bit_in} ^ KEY_BYTE;
      w_pop       = r_out_valid && out_ready;
      w_full      = (r_occ == OCC_FULL);
      w_push      = w_complete && (!w_full || w_pop);
      w_drop      = w_complete && !w_push;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_bit_cnt;
      w_occ_nxt   = r_occ;
      w_rd_nxt    = r_rd_ptr;
      w_head_nxt  = r_out_data;

      if (frame_start) begin
         w_shift_nxt = {6'b0, bit_in & bit_valid};
         w_cnt_nxt   = bit_valid ? 3'd1 : 3'd0;
      end else if (bit_valid) begin
         w_shift_nxt = {r_shift[5:0], bit_in};
         w_cnt_nxt   = r_bit_cnt + 3'd1;
      end

      if (w_push && !w_pop)
         w_occ_nxt = r_occ + OCC_W'(1);
      else if (!w_push && w_pop)
         w_occ_nxt = r_occ - OCC_W'(1);

      if (w_pop)
         w_rd_nxt = r_rd_ptr + PTR_W'(1);

      // Head is the incoming byte when it lands exactly at the next read slot
      if (w_occ_nxt != '0) begin
         if (w_push && (r_wr_ptr == w_rd_nxt))
            w_head_nxt = w_byte;
         else
            w_head_nxt = r_mem[w_rd_nxt];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_occ         <= '0;
         r_out_data    <= '0;
         r_out_valid   <= 1'b0;
         r_overflow    <= 1'b0;
         r_frame_count <= '0;
         r_busy        <= 1'b0;
      end else begin
         r_shift     <= w_shift_nxt;
         r_bit_cnt   <= w_cnt_nxt;
         r_rd_ptr    <= w_rd_nxt;
         r_occ       <= w_occ_nxt;
         r_out_data  <= w_head_nxt;
         r_out_valid <= (w_occ_nxt != '0);
         r_busy      <= (w_cnt_nxt != 3'd0);
         if (w_push) begin
            r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
            r_frame_count <= r_frame_count + 8'd1;
         end
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clr_ovf)
            r_overflow <= 1'b0;
      end
   end

   // Storage array needs no reset; occupancy qualifies every read
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_byte;
   end

   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign overflow    = r_overflow;
   assign frame_count = r_frame_count;
   assign busy        = r_busy;

endmodule

// File: tb/tb_serdes_cipher_deserializer.sv
// Directed bench for serdes_cipher_deserializer with hand-computed expected bytes.
module tb_serdes_cipher_deserializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bit_valid;
   logic       bit_in;
   logic       frame_start;
   logic       clr_ovf;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       overflow;
   logic [7:0] frame_count;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   serdes_cipher_deserializer #(.KEY_BYTE(8'h34), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_valid   (bit_valid),
      .bit_in      (bit_in),
      .frame_start (frame_start),
      .clr_ovf     (clr_ovf),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overflow    (overflow),
      .frame_count (frame_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bit_valid = 1'b1;
      bit_in    = b;
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
         if (i > 0) repeat (gap) tick();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n       = 1'b0;
      bit_valid   = 1'b0;
      bit_in      = 1'b0;
      frame_start = 1'b0;
      clr_ovf     = 1'b0;
      out_ready   = 1'b0;
      tick();
      chk1("rst_valid", out_valid, 1'b0);
      chk8("rst_data", out_data, 8'h00);
      chk8("rst_count", frame_count, 8'h00);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_ovf", overflow, 1'b0);
      rst_n = 1'b1;
      tick();

      // 1: basic byte 0x61 -> 0x55, out_ready held high
      out_ready = 1'b1;
      for (int i = 7; i >= 1; i--) send_bit(i == 6 || i == 5);
      chk1("t1_busy_mid", busy, 1'b1);
      chk1("t1_valid_early", out_valid, 1'b0);
      send_bit(1'b1);
      chk1("t1_valid", out_valid, 1'b1);
      chk8("t1_data", out_data, 8'h55);
      chk8("t1_count", frame_count, 8'd1);
      chk1("t1_busy_done", busy, 1'b0);
      tick();
      chk1("t1_valid_drop", out_valid, 1'b0);

      // 2: gapped 0x61, held at head to observe a single push
      out_ready = 1'b0;
      send_byte(8'h61, 3);
      chk1("t2_valid", out_valid, 1'b1);
      chk8("t2_data", out_data, 8'h55);
      chk8("t2_count", frame_count, 8'd2);
      out_ready = 1'b1;
      tick();
      chk1("t2_single", out_valid, 1'b0);
      out_ready = 1'b0;

      // 3: realign after 3 bits
      do_reset();
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      chk1("t3_busy", busy, 1'b1);
      frame_start = 1'b1;
      send_bit(1'b1);
      frame_start = 1'b0;
      chk1("t3_busy_realign", busy, 1'b1);
      for (int i = 0; i < 6; i++) send_bit(1'b1);
      chk1("t3_no_early", out_valid, 1'b0);
      send_bit(1'b1);
      chk1("t3_valid", out_valid, 1'b1);
      chk8("t3_data", out_data, 8'hCB);
      chk8("t3_count", frame_count, 8'd1);
      out_ready = 1'b1;
      tick();
      chk1("t3_single", out_valid, 1'b0);
      out_ready = 1'b0;

      // 4: overflow on fifth byte
      do_reset();
      for (int k = 0; k < 5; k++) send_byte(8'h34 + 8'(k) + ((k == 4) ? 8'h00 : 8'h00), 0);
      chk1("t4_ovf", overflow, 1'b1);
      chk8("t4_count", frame_count, 8'd4);
      chk8("t4_head", out_data, 8'h00);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk1("t4_drain_valid", out_valid, 1'b1);
         chk8("t4_drain_data", out_data, 8'(k));
         tick();
      end
      chk1("t4_empty", out_valid, 1'b0);
      out_ready = 1'b0;
      chk1("t4_sticky", overflow, 1'b1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk1("t4_clr", overflow, 1'b0);

      // 5: full FIFO, pop coincides with the completing push
      for (int k = 0; k < 4; k++) send_byte(8'h40 + 8'(k), 0);
      chk8("t5_count_full", frame_count, 8'd8);
      chk8("t5_head_full", out_data, 8'h74);
      for (int i = 7; i >= 1; i--) send_bit(i == 6 || i == 2);
      out_ready = 1'b1;
      send_bit(1'b0);
      chk1("t5_no_ovf", overflow, 1'b0);
      chk8("t5_count", frame_count, 8'd9);
      begin
         logic [7:0] exp_q [4];
         exp_q = '{8'h75, 8'h76, 8'h77, 8'h70};
         for (int k = 0; k < 4; k++) begin
            chk1("t5_drain_valid", out_valid, 1'b1);
            chk8("t5_drain_data", out_data, exp_q[k]);
            tick();
         end
      end
      chk1("t5_empty", out_valid, 1'b0);
      out_ready = 1'b0;

      // 6: async reset mid-byte with two bytes queued
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      chk1("t6_pre_valid", out_valid, 1'b1);
      chk1("t6_pre_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("t6_rst_valid", out_valid, 1'b0);
      chk8("t6_rst_data", out_data, 8'h00);
      chk8("t6_rst_count", frame_count, 8'h00);
      chk1("t6_rst_busy", busy, 1'b0);
      chk1("t6_rst_ovf", overflow, 1'b0);
      #2;
      rst_n = 1'b1;
      tick();
      send_byte(8'hA5, 0);
      chk1("t6_valid", out_valid, 1'b1);
      chk8("t6_data", out_data, 8'h91);
      chk8("t6_count", frame_count, 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
